reset_sequencer: RTL

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_pkg.sv | 25 ++
 rtl/reset_sync2.sv | 24 ++
 rtl/reset_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/reset_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// parameter defaults and the shared-counter width helper.
package reset_pkg;

  localparam int unsigned DEF_CHANNELS    = 4;
  localparam int unsigned DEF_HOLD_CYCLES = 8;
  localparam int unsigned DEF_STAGE_GAP   = 4;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    DONE    = 2'd2
  } seq_state_t;

  // One counter serves both the lock-hold window and the staggered release span.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned ch,
                                            input int unsigned gap);
    int unsigned span;
    span = (ch - 1) * gap;
    if (hold > span) span = hold;
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/reset_sync2.sv
// Two-flop synchroniser for a single asynchronous level; output is 0 during reset.
module reset_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/reset_sequencer.sv
// Staggered multi-channel reset release gated by a synchronised lock input.
// Optional macro RESET_SEQUENCER_LOCK_MON_EN: lock loss in DONE restarts the sequence.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int unsigned CHANNELS    = DEF_CHANNELS,
  parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic                CLK_IN,
  input  logic                RST_IN,
  input  logic                REQ_IN,
  input  logic                LOCK_IN,
  output logic [CHANNELS-1:0] RST_OUT,
  output logic                BUSY_OUT,
  output logic                DONE_OUT
);

  localparam int unsigned    CW        = cnt_width(HOLD_CYCLES, CHANNELS, STAGE_GAP);
  localparam logic [CW-1:0]  HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]  REL_LAST  = CW'((CHANNELS - 1) * STAGE_GAP);

  seq_state_t          r_state;
  logic [CW-1:0]       r_cnt;
  logic [CHANNELS-1:0] r_rst;
  logic                r_done;
  logic                r_req_d;

  seq_state_t          w_state_nxt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [CHANNELS-1:0] w_rst_nxt;
  logic                w_done_nxt;
  logic [CW-1:0]       w_cnt_inc;
  logic                w_lock;
  logic                w_req_edge;
  logic                w_restart;

  reset_sync2 u_lock_sync (
    .i_clk (CLK_IN),
    .i_rst (RST_IN),
    .i_d   (LOCK_IN),
    .o_q   (w_lock)
  );

  // History resets to 1 so a request held high across reset is not a new edge.
  assign w_req_edge = REQ_IN & ~r_req_d;
  assign w_cnt_inc  = r_cnt + 1'b1;

`ifdef RESET_SEQUENCER_LOCK_MON_EN
  assign w_restart = w_req_edge | ((r_state == DONE) & ~w_lock);
`else
  assign w_restart = w_req_edge;
`endif

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      r_state <= HOLD;
      r_cnt   <= '0;
      r_rst   <= '1;
      r_done  <= 1'b0;
      r_req_d <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst   <= w_rst_nxt;
      r_done  <= w_done_nxt;
      r_req_d <= REQ_IN;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rst_nxt   = r_rst;
    w_done_nxt  = r_done;
    if (w_restart) begin
      w_state_nxt = HOLD;
      w_cnt_nxt   = '0;
      w_rst_nxt   = '1;
      w_done_nxt  = 1'b0;
    end else begin
      case (r_state)
        HOLD: begin
          if (!w_lock) begin
            w_cnt_nxt = '0;
          end else if (r_cnt == HOLD_LAST) begin
            w_cnt_nxt    = '0;
            w_rst_nxt[0] = 1'b0;
            // A single channel finishes on the hold exit itself.
            if (CHANNELS == 1) begin
              w_state_nxt = DONE;
              w_done_nxt  = 1'b1;
            end else begin
              w_state_nxt = RELEASE;
            end
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        RELEASE: begin
          w_cnt_nxt = w_cnt_inc;
          for (int unsigned k = 1; k < CHANNELS; k++) begin
            if (w_cnt_inc == CW'(k * STAGE_GAP)) w_rst_nxt[k] = 1'b0;
          end
          if (w_cnt_inc == REL_LAST) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
          end
        end
        DONE: begin
        end
        default: begin
          w_state_nxt = HOLD;
          w_cnt_nxt   = '0;
          w_rst_nxt   = '1;
          w_done_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign RST_OUT  = r_rst;
  assign DONE_OUT = r_done;
  assign BUSY_OUT = (r_state != DONE);

endmodule
